// File: rtl/proc_pkg.sv
// Shared definitions for the processor core slice.
// Holds default widths, the instruction opcode map, the instruction field
// layout and the fetch FSM state encoding.
package proc_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_STORE  = 4'd2;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_ROT    = 4'd6;
  localparam logic [3:0] OP_SHIFT  = 4'd7;
  localparam logic [3:0] OP_HALT   = 4'd8;
  localparam logic [3:0] OP_CMP    = 4'd9;

  // Instruction layout: opcode in the top nibble, two 12-bit address fields.
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned SRC_MSB = 23;
  localparam int unsigned SRC_LSB = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 0;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: DEPTH x W synchronous FIFO with flush.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i (accepted when not full, or when popping)
//   pop_i        drop the head entry (ignored when empty)
//   flush_i      discard all entries; overrides push and pop
//   wdata_i      entry to write
//   rdata_o      head entry
//   full_o       DEPTH entries held
//   empty_o      no entries held
//   count_o      number of entries held
module ifu_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 44
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch stage.
// Reads instruction words over a single-outstanding req/ack memory port,
// buffers {pc, word} pairs and hands them to decode over valid/ready.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_req/mem_addr         read request and its word address (held until ack)
//   mem_ack/mem_rdata        read completion and data
//   instr_valid/instr/instr_pc/instr_ready   decode handshake (head of buffer)
//   redirect/redirect_pc     taken-branch pulse: flush and refetch from redirect_pc
//   halt                     level: stop issuing new fetches
//   halted                   halt applied and no request outstanding
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              drop_q, drop_d;
  logic              halted_q, halted_d;

  logic              push, pop, flush, full, empty;
  logic [CW-1:0]     count, occ;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W+DATA_W-1:0] head;

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({req_addr_q, mem_rdata}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign instr_valid = !empty;
  assign instr       = head[DATA_W-1:0];
  assign instr_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign mem_req     = (state_q == FS_REQ);
  // The request address lives in its own register so a redirect can retarget
  // fetch_pc while the outstanding request keeps its address until acked.
  assign mem_addr    = (state_q == FS_REQ) ? req_addr_q : '0;
  assign halted      = halted_q;
  assign flush       = redirect;
  assign pop         = instr_valid && instr_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    pc_next    = fetch_pc_q;
    occ        = count;
    unique case (state_q)
      FS_IDLE: begin
        if (!redirect && !halt && !full && occ < DEPTH_V) begin
          state_d    = FS_REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      FS_REQ: begin
        if (mem_ack) begin
          drop_d  = 1'b0;
          state_d = FS_IDLE;
          if (!drop_q && !redirect) begin
            push    = 1'b1;
            pc_next = fetch_pc_q + ADDR_W'(1);
            occ     = count + CW'(1);
          end
          fetch_pc_d = pc_next;
          // Chain straight into the next request when there is room.
          if (!redirect && !halt && occ < DEPTH_V) begin
            state_d    = FS_REQ;
            req_addr_d = pc_next;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc;
    halted_d = halt && !redirect && (state_d == FS_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import proc_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (12'h000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] sb[$];
  logic [AW-1:0]    pop_log[$];
  logic [AW-1:0]    exp_fetch = '0;
  logic [AW-1:0]    drop_addr = '0;
  logic [AW-1:0]    redir_pc  = '0;
  bit               drop_flag = 1'b0;
  bit               redir_req = 1'b0;
  bit               ready_en  = 1'b1;
  int               ack_delay = 1;
  int               wait_cnt  = 0;
  int               n_acks    = 0;
  int               n_pops    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      12'h000: return 32'h0000_0003;
      12'h001: return 32'h0000_0004;
      12'h002: return 32'h5000_0001;
      12'h003: return 32'h5000_1001;
      default: return {20'hA5000, a};
    endcase
  endfunction

  function automatic logic [15:0] pc_at(input int idx);
    if (idx < pop_log.size()) return {4'h0, pop_log[idx]};
    return 16'hDEAD;
  endfunction

  // One clock: at the falling edge observe the DUT, model memory and decode,
  // and drive inputs for the following rising edge.
  task automatic cycle();
    bit do_redir;
    logic [AW+DW-1:0] e;
    @(negedge clk);
    mem_ack     = 1'b0;
    redirect    = 1'b0;
    instr_ready = ready_en;
    do_redir    = redir_req;
    redir_req   = 1'b0;
    if (do_redir) begin
      redirect    = 1'b1;
      redirect_pc = redir_pc;
      sb.delete();
    end
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
        n_acks++;
        check("fetch_addr", mem_addr, drop_flag ? drop_addr : exp_fetch);
        if (!drop_flag && !do_redir) begin
          sb.push_back({mem_addr, mem_rdata});
          exp_fetch = exp_fetch + 1'b1;
        end
        drop_flag = 1'b0;
      end else begin
        wait_cnt++;
      end
    end
    if (do_redir) begin
      if (mem_req && !mem_ack) begin
        if (!drop_flag) drop_addr = exp_fetch;
        drop_flag = 1'b1;
      end
      exp_fetch = redir_pc;
    end
    if (instr_valid && instr_ready && !do_redir) begin
      n_pops++;
      pop_log.push_back(instr_pc);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", instr_pc, e[AW+DW-1:DW]);
        check("pop_instr", instr, e[DW-1:0]);
      end
    end
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    mem_ack     = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_halted", halted, 0);
    sb.delete();
    pop_log.delete();
    exp_fetch = '0;
    drop_flag = 1'b0;
    redir_req = 1'b0;
    wait_cnt  = 0;
    n_acks    = 0;
    n_pops    = 0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = stray;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int budget = 300;
    while (n_pops < n && budget > 0) begin
      cycle();
      budget--;
    end
    check(tag, n_pops >= n, 1);
  endtask

  // Wait until a request has been visible for exactly one sampled cycle.
  task automatic wait_req_start(input bit any, input logic [AW-1:0] addr, input string tag);
    int budget = 200;
    bit found = 1'b0;
    while (!found && budget > 0) begin
      cycle();
      budget--;
      if (mem_req && wait_cnt == 1 && (any || mem_addr == addr)) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    int base;
    int acks0;
    int budget;
    bit req_seen;
    logic [AW-1:0] t4_exp [4];

    // 1: sequential fetch, ack one cycle after request
    ready_en  = 1'b1;
    ack_delay = 1;
    do_reset(1'b0);
    wait_pops(4, "t1_pops");
    for (int i = 0; i < 4; i++) check("t1_pc", pc_at(i), i);

    // 2: decode stalled, buffer fills, then drains and fetch resumes
    ready_en  = 1'b0;
    ack_delay = 0;
    do_reset(1'b0);
    repeat (20) cycle();
    check("t2_acks", n_acks, DEPTH);
    check("t2_req_idle", mem_req, 0);
    check("t2_full_valid", instr_valid, 1);
    ready_en = 1'b1;
    wait_pops(5, "t2_pops");
    check("t2_resume_pc", pc_at(4), 4);

    // 3: redirect while request to 0x002 outstanding
    ack_delay = 3;
    do_reset(1'b0);
    wait_req_start(1'b0, 12'h002, "t3_req2_seen");
    redir_pc  = 12'h005;
    redir_req = 1'b1;
    base = n_pops;
    wait_pops(base + 1, "t3_pops");
    check("t3_first_pc", pc_at(base), 12'h005);

    // 4: address wrap after redirect to 0xFFE
    ack_delay = 1;
    redir_pc  = 12'hFFE;
    redir_req = 1'b1;
    base = n_pops;
    wait_pops(base + 4, "t4_pops");
    t4_exp[0] = 12'hFFE;
    t4_exp[1] = 12'hFFF;
    t4_exp[2] = 12'h000;
    t4_exp[3] = 12'h001;
    for (int i = 0; i < 4; i++) check("t4_pc", pc_at(base + i), t4_exp[i]);

    // 5: halt with a request outstanding
    ack_delay = 3;
    wait_req_start(1'b1, '0, "t5_req_seen");
    halt  = 1'b1;
    acks0 = n_acks;
    budget = 20;
    while (n_acks == acks0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("t5_outstanding_acked", n_acks > acks0, 1);
    req_seen = 1'b0;
    repeat (8) begin
      cycle();
      if (mem_req) req_seen = 1'b1;
    end
    check("t5_no_req", req_seen, 0);
    check("t5_halted", halted, 1);
    check("t5_drained", sb.size(), 0);
    halt = 1'b0;
    repeat (2) cycle();
    check("t5_unhalted", halted, 0);
    base = n_pops;
    wait_pops(base + 2, "t5_resume_pops");

    // 6a: reset in the middle of a request
    wait_req_start(1'b1, '0, "t6_req_seen");
    do_reset(1'b0);

    // 6b: reset with a full buffer, then a stray ack after release
    ready_en  = 1'b0;
    ack_delay = 0;
    repeat (12) cycle();
    check("t6_full_valid", instr_valid, 1);
    check("t6_full_acks", n_acks, DEPTH);
    ready_en = 1'b1;
    do_reset(1'b1);
    cycle();
    check("t6_stray_ignored", instr_valid, 0);
    wait_pops(2, "t6_pops");
    check("t6_first_pc", pc_at(0), 0);
    check("t6_second_pc", pc_at(1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
